// File: rtl/classification.sv
// Image classifier: scans a captured 4-bit pixel image one pixel per clock,
// counts dark interior pixels and flags the image as diseased when that
// count reaches MIN_DARK.
module classification #(
  parameter int VECTOR_SIZE = 4096,
  parameter int DARK_THR    = 3,
  parameter int MIN_DARK    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [VECTOR_SIZE*4-1:0] test_vector,
  output logic                     result,
  output logic                     done
);

  // Elaboration-time integer square root gives the image side length.
  function automatic int isqrt(input int n);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= n) r = r + 1;
    return r;
  endfunction

  localparam int IMG_W = isqrt(VECTOR_SIZE);
  localparam int IDX_W = $clog2(VECTOR_SIZE);
  localparam int CNT_W = $clog2(VECTOR_SIZE + 1);
  localparam int RC_W  = $clog2(IMG_W);
  localparam int VW    = VECTOR_SIZE * 4;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(VECTOR_SIZE - 1);
  localparam logic [RC_W-1:0]  LAST_RC   = RC_W'(IMG_W - 1);
  localparam logic [RC_W-1:0]  INNER_MAX = RC_W'(IMG_W - 2);
  localparam logic [4:0]       THR       = 5'(DARK_THR);
  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_DARK);

  typedef enum logic [1:0] {IDLE, SCAN, DECIDE, DONE} state_t;

  state_t            state;
  logic [VW-1:0]     vec;   // captured image, shifted down one pixel per scan step
  logic [IDX_W-1:0]  idx;
  logic [RC_W-1:0]   row;
  logic [RC_W-1:0]   col;
  logic [CNT_W-1:0]  cnt;

  logic [3:0] pix;
  logic       interior;
  logic       dark;

  // The pixel under examination is always the low nibble of the shifted copy;
  // row/col are tracked incrementally so no divider is needed.
  assign pix      = vec[3:0];
  assign interior = (row != '0) && (row <= INNER_MAX) && (col != '0) && (col <= INNER_MAX);
  assign dark     = ({1'b0, pix} < THR);

  // Control FSM with registered result/done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      vec    <= '0;
      idx    <= '0;
      row    <= '0;
      col    <= '0;
      cnt    <= '0;
      result <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec   <= test_vector;
            idx   <= '0;
            row   <= '0;
            col   <= '0;
            cnt   <= '0;
            done  <= 1'b0;
            state <= SCAN;
          end
        end
        SCAN: begin
          // Count never exceeds VECTOR_SIZE, which CNT_W can always hold.
          if (interior && dark) cnt <= cnt + CNT_W'(1);
          vec <= {4'b0, vec[VW-1:4]};
          if (idx == LAST_IDX) begin
            state <= DECIDE;
          end else begin
            idx <= idx + IDX_W'(1);
            if (col == LAST_RC) begin
              col <= '0;
              row <= row + RC_W'(1);
            end else begin
              col <= col + RC_W'(1);
            end
          end
        end
        DECIDE: begin
          result <= (cnt >= MIN_C);
          done   <= 1'b1;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_classification.sv
// Bench for classification (64-pixel image): a countdown-based behavioural
// model is compared against done/result every cycle, plus directed scenarios
// with literal expectations and a randomized phase.
module tb_classification;
  localparam int VS   = 64;
  localparam int W    = 8;
  localparam int THR  = 3;
  localparam int MIND = 2;
  localparam int LAT  = VS + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [VS*4-1:0] test_vector = '0;
  logic          result;
  logic          done;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  classification #(.VECTOR_SIZE(VS), .DARK_THR(THR), .MIN_DARK(MIND)) dut (
    .clk(clk), .rst(rst), .start(start), .test_vector(test_vector),
    .result(result), .done(done)
  );

  always #5 clk = ~clk;

  // Reference classification straight from the rules: count interior pixels below threshold.
  function automatic bit classify(input logic [VS*4-1:0] v);
    int n;
    logic [3:0] p;
    n = 0;
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++) begin
        p = v[(r*W + c)*4 +: 4];
        if (r >= 1 && r <= W-2 && c >= 1 && c <= W-2 && int'(p) < THR) n++;
      end
    return n >= MIND;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a run is a countdown of VS+1 edges from capture.
  int              m_cnt = 0;
  logic [VS*4-1:0] m_snap = '0;
  logic            m_done = 1'b0;
  logic            m_res = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt <= 0; m_snap <= '0; m_done <= 1'b0; m_res <= 1'b0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_snap <= test_vector; m_done <= 1'b0; m_cnt <= LAT;
      end
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_res  <= classify(m_snap);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_done", done, m_done);
      chk("cyc_result", result, m_res);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [VS*4-1:0] fill(input int val);
    logic [VS*4-1:0] v;
    for (int i = 0; i < VS; i++) v[i*4 +: 4] = 4'(val);
    return v;
  endfunction

  function automatic logic [VS*4-1:0] rnd_img();
    logic [VS*4-1:0] v;
    for (int i = 0; i < VS; i++)
      v[i*4 +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(3, 15));
    return v;
  endfunction

  // Directed run: capture vec, optionally pulse start at scan edge stray, scramble
  // test_vector after capture, and require done exactly LAT edges after capture.
  task automatic run(input string name, input logic [VS*4-1:0] vec, input logic exp, input int stray);
    int edges;
    test_vector = vec;
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk({name, "_done_clr"}, done, 1'b0);
    edges = 0;
    while (!done && edges < 200) begin
      start = (edges == stray);
      test_vector = rnd_img();
      step(1);
      edges++;
    end
    start = 1'b0;
    checks++;
    if (edges != LAT) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges expected %0d", name, edges, LAT);
    end
    chk({name, "_result"}, result, exp);
  endtask

  logic [VS*4-1:0] v1, v27, v28, v29, v30;
  bit hold;

  initial begin
    v1  = 256'h1245541125555541355555544555555545555555455555542555554112454311;
    v27 = fill(5); v27[18*4 +: 4] = 4'd0; v27[27*4 +: 4] = 4'd1;
    v28 = fill(5); v28[18*4 +: 4] = 4'd0;
    v29 = fill(5); v30 = fill(5);
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++)
        if (r == 0 || r == W-1 || c == 0 || c == W-1) begin
          v29[(r*W+c)*4 +: 4] = 4'd0;
        end else begin
          v30[(r*W+c)*4 +: 4] = 4'd3;
        end

    // Pin the model to hand-derived answers.
    chk("model_v1", classify(v1), 1'b0);
    chk("model_v27", classify(v27), 1'b1);
    chk("model_v28", classify(v28), 1'b0);
    chk("model_v29", classify(v29), 1'b0);
    chk("model_v30", classify(v30), 1'b0);

    #1;
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 1'b0);
    step(2);
    rst = 1'b1;
    chk_on = 1'b1;
    step(2);

    run("v1", v1, 1'b0, -1);
    step(10);
    chk("v1_hold_done", done, 1'b1);
    chk("v1_hold_result", result, 1'b0);
    run("v27", v27, 1'b1, -1);
    run("v28_from_done", v28, 1'b0, -1);
    run("v29", v29, 1'b0, -1);
    run("v30", v30, 1'b0, -1);
    run("stray_start", v27, 1'b1, 10);

    // Mid-run reset: result must hold 1 through the scan, then clear asynchronously.
    test_vector = v28; start = 1'b1; step(1); start = 1'b0;
    step(30);
    chk("scan_result_held", result, 1'b1);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_done", done, 1'b0);
    chk("async_rst_result", result, 1'b0);
    step(2);
    rst = 1'b1;
    step(LAT + 5);
    chk("idle_after_rst", done, 1'b0);

    // Randomized phase: random images, sporadic or held start, rare async resets.
    hold = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 299) == 0) hold = ~hold;
      start = hold || ($urandom_range(0, 24) == 0);
      test_vector = rnd_img();
      if ($urandom_range(0, 699) == 0) begin
        #3 rst = 1'b0;
        step(1);
        rst = 1'b1;
      end else begin
        step(1);
      end
    end
    start = 1'b0;
    step(LAT + 2);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/classification.md
CLASSIFICATION -- requirements
Module: classification

Interface
REQ-001 The module SHALL have parameter VECTOR_SIZE, default 4096, meaning the number of 4-bit pixels in the input image; it SHALL be a perfect square of at least 9.
REQ-002 The module SHALL have parameter DARK_THR, default 3, meaning a pixel value strictly below this is dark.
REQ-003 The module SHALL have parameter MIN_DARK, default 2, meaning the minimum dark-pixel count that classifies the image as diseased.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-006 The module SHALL have port start, input, 1 bit: the request to begin classification, sampled on clk.
REQ-007 The module SHALL have port test_vector, input, VECTOR_SIZE*4 bits: the image; pixel i occupies bits [4i+3:4i].
REQ-008 The module SHALL have port result, output, 1 bit: 0 = healthy, 1 = diseased; valid while done=1.
REQ-009 The module SHALL have port done, output, 1 bit: classification complete, held high.

Function
REQ-010 IMG_W SHALL equal the integer square root of VECTOR_SIZE, computed at elaboration; pixel i is at row i/IMG_W, column i%IMG_W.
REQ-011 Interior pixels SHALL be those with row and column both in 1..IMG_W-2; border pixels SHALL never count as dark.
REQ-012 The FSM SHALL have states IDLE, SCAN, DECIDE and DONE.
REQ-013 In IDLE or DONE, start=1 at a clock edge SHALL cause the following on that edge:
- test_vector is captured into an internal register;
- the pixel index and dark count are cleared;
- done is cleared to 0;
- the state moves to SCAN.
REQ-014 The captured copy SHALL be used for the whole run; test_vector changes after the capture edge SHALL have no effect.
REQ-015 In SCAN, each edge SHALL examine one pixel at the current index (0 up to VECTOR_SIZE-1) and add 1 to the dark count if that pixel is interior and its value is below DARK_THR.
REQ-016 After pixel VECTOR_SIZE-1 is examined, the state SHALL move to DECIDE.
REQ-017 The dark counter SHALL be clog2(VECTOR_SIZE+1) bits wide and SHALL NOT overflow.
REQ-018 In DECIDE, one edge SHALL set result = (dark count >= MIN_DARK), set done = 1 and move to DONE.
REQ-019 Latency: done SHALL first read 1 after exactly VECTOR_SIZE+1 rising edges following the start-capture edge (65 for VECTOR_SIZE=64).
REQ-020 In DONE, result and done SHALL hold until the next accepted start or reset.
REQ-021 start SHALL be ignored while in SCAN or DECIDE.
REQ-022 start held high continuously SHALL re-trigger a run on the first edge in DONE.
REQ-023 result SHALL change only in DECIDE or on reset; it SHALL keep its previous value from start capture until DECIDE.

Reset
REQ-024 While rst=0, the state SHALL be IDLE and result, done, the dark count, the index and the captured vector SHALL all be 0, regardless of clk.
REQ-025 Reset asserted mid-run SHALL abort the run immediately; after release, the module SHALL wait in IDLE for a new start.

Verification (VECTOR_SIZE=64, DARK_THR=3, MIN_DARK=2)
REQ-026 Scenario: test_vector = 256'h1245541125555541355555544555555545555555455555542555554112454311, one-cycle start pulse -> done rises 65 edges after capture, result=0; done stays high and result stays 0 for at least 10 further cycles.
REQ-027 Scenario: all pixels 5 except index 18 (row 2, col 2) = 0 and index 27 = 1 -> result=1.
REQ-028 Scenario: all pixels 5 except only index 18 = 0 -> result=0 (count 1 < MIN_DARK).
REQ-029 Scenario: all border pixels 0, all interior pixels 5 -> result=0.
REQ-030 Scenario: interior pixels 3 and border pixels 5 -> result=0 (the threshold is strict).
REQ-031 Scenario: rst driven to 0 at scan cycle 30 -> done=0 and result=0 immediately, with no clock edge required.
REQ-032 Scenario: start pulsed at scan cycle 10 -> ignored; done still at edge 65 after the original capture.
REQ-033 Scenario: a second run started from DONE -> done reads 0 on the capture edge, and the new result is correct.
